// File: rtl/ecc_enc_pkg.sv
// rtl/ecc_enc_pkg.sv - shared types, per-mode sizes and position map for the SECDED encoder
package ecc_enc_pkg;

    typedef enum logic [1:0] {
        MOD_8_4     = 2'b00,
        MOD_16_11   = 2'b01,
        MOD_32_26   = 2'b10,
        MOD_ILLEGAL = 2'b11
    } mod_e;

    localparam int K_8_4   = 4;
    localparam int P_8_4   = 4;
    localparam int K_16_11 = 11;
    localparam int P_16_11 = 5;
    localparam int K_32_26 = 26;
    localparam int P_32_26 = 6;

    // Widest Hamming part (overall parity excluded).
    localparam int HAM_W = P_32_26 - 1;

    function automatic int mod_k(input mod_e m);
        int k;
        case (m)
            MOD_8_4:   k = K_8_4;
            MOD_16_11: k = K_16_11;
            MOD_32_26: k = K_32_26;
            default:   k = 0;
        endcase
        return k;
    endfunction

    // Info bit idx sits at the idx-th integer >= 3 that is not a power of two.
    function automatic int info_pos(input int idx);
        int res;
        int cnt;
        res = 0;
        cnt = 0;
        for (int v = 3; v < 256; v++) begin
            if (((v & (v - 1)) != 0) && (res == 0)) begin
                if (cnt == idx) begin
                    res = v;
                end
                cnt = cnt + 1;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/ecc_hamming_par.sv
// rtl/ecc_hamming_par.sv - combinational Hamming parity bits for the selected mode
module ecc_hamming_par
    import ecc_enc_pkg::*;
#(
    parameter int MAX_INFO_WIDTH = 26
) (
    input  mod_e                      mod,
    input  logic [MAX_INFO_WIDTH-1:0] info,
    output logic [HAM_W-1:0]          ham
);

    int k;

    // Positions of the active info bits never exceed 2^(P-1)-1, so the unused
    // upper parity bits of the narrower modes fall out as zero.
    always_comb begin
        ham = '0;
        k   = mod_k(mod);
        for (int i = 0; i < MAX_INFO_WIDTH; i++) begin
            if ((i < k) && info[i]) begin
                ham = ham ^ HAM_W'(info_pos(i));
            end
        end
    end

endmodule

// File: rtl/ecc_enc_pipe.sv
// rtl/ecc_enc_pipe.sv - two-stage multi-mode SECDED encoder with valid/ready streaming
module ecc_enc_pipe
    import ecc_enc_pkg::*;
#(
    parameter int MAX_CODEWORD_WIDTH = 32,
    parameter int MAX_INFO_WIDTH     = 26,
    parameter int CNT_W              = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [MAX_INFO_WIDTH-1:0]     in_info,
    input  logic [1:0]                    in_mod,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [MAX_CODEWORD_WIDTH-1:0] out_data,
    output logic                          out_err,
    output logic [CNT_W-1:0]              enc_cnt
);

    logic                          s1_valid;
    mod_e                          s1_mod;
    logic [MAX_INFO_WIDTH-1:0]     s1_info;
    logic [HAM_W-1:0]              s1_ham;

    mod_e                          in_mod_e;
    logic [MAX_INFO_WIDTH-1:0]     info_masked;
    logic [HAM_W-1:0]              ham;
    logic [MAX_CODEWORD_WIDTH-1:0] cw;
    logic                          cw_err;
    logic                          s2_adv;
    logic                          in_fire;
    int                            in_k;

    assign in_mod_e = mod_e'(in_mod);
    assign s2_adv   = !out_valid || out_ready;
    assign in_ready = !s1_valid || s2_adv;
    assign in_fire  = in_valid && in_ready;

    always_comb begin
        info_masked = '0;
        in_k        = mod_k(in_mod_e);
        for (int i = 0; i < MAX_INFO_WIDTH; i++) begin
            info_masked[i] = in_info[i] && (i < in_k);
        end
    end

    ecc_hamming_par #(
        .MAX_INFO_WIDTH(MAX_INFO_WIDTH)
    ) u_ham (
        .mod (in_mod_e),
        .info(info_masked),
        .ham (ham)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_mod   <= MOD_8_4;
            s1_info  <= '0;
            s1_ham   <= '0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_mod  <= in_mod_e;
                s1_info <= info_masked;
                s1_ham  <= ham;
            end
        end
    end

    // Stage-1 info is already masked, so the overall parity can fold the active slice only.
    always_comb begin
        cw     = '0;
        cw_err = 1'b0;
        case (s1_mod)
            MOD_8_4: begin
                cw[K_8_4+P_8_4-1:0] = {s1_info[K_8_4-1:0],
                                       (^s1_info[K_8_4-1:0]) ^ (^s1_ham[P_8_4-2:0]),
                                       s1_ham[P_8_4-2:0]};
            end
            MOD_16_11: begin
                cw[K_16_11+P_16_11-1:0] = {s1_info[K_16_11-1:0],
                                           (^s1_info[K_16_11-1:0]) ^ (^s1_ham[P_16_11-2:0]),
                                           s1_ham[P_16_11-2:0]};
            end
            MOD_32_26: begin
                cw[K_32_26+P_32_26-1:0] = {s1_info[K_32_26-1:0],
                                           (^s1_info[K_32_26-1:0]) ^ (^s1_ham[P_32_26-2:0]),
                                           s1_ham[P_32_26-2:0]};
            end
            default: begin
                cw_err = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_err   <= 1'b0;
        end else if (s2_adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_data <= cw;
                out_err  <= cw_err;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            enc_cnt <= '0;
        end else if (out_valid && out_ready && (enc_cnt != {CNT_W{1'b1}})) begin
            enc_cnt <= enc_cnt + CNT_W'(1);
        end
    end

endmodule
